// File: rtl/ram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ram_rd_arbiter
//
// Round-robin arbiter sharing the single read port of one dual_port_ram among
// REQ_NUM read clients. Each cycle at most one valid client is granted; its
// address is driven to the RAM together with the read strobe. A small tag
// pipeline, as deep as the RAM read latency (1 + RAM_OUT_REG), remembers which
// client issued each read so the returned data can be flagged with a one-hot
// response strobe for that client.
//
// Parameters:
//   DATA_WIDTH  - RAM word width
//   ADDR_WIDTH  - RAM address width
//   REQ_NUM     - number of read clients (2..16)
//   RAM_OUT_REG - 1 when the RAM output register is used (latency 2)
//
// Ports:
//   clk_i               in   clock (also the RAM read clock)
//   rst_n_i             in   asynchronous active-low reset
//   req_valid_i         in   per-client read request
//   req_addr_i          in   client i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready_o         out  one-hot grant (combinational)
//   resp_valid_o        out  one-hot response strobe
//   resp_data_o         out  read data shared by all clients
//   ram_rd_addr_o       out  RAM read address
//   ram_rd_o            out  RAM read enable
//   ram_output_reg_en_o out  RAM output register enable
//   ram_rd_data_i       in   RAM read data
//   grant_cnt_o         out  per-client 16-bit saturating grant counters
//                            (present only with RAM_RD_ARB_STATS_EN defined)
//
// Optional feature macro: RAM_RD_ARB_STATS_EN
// ---------------------------------------------------------------------------
module ram_rd_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int REQ_NUM     = 4,
    parameter int RAM_OUT_REG = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    output logic [REQ_NUM-1:0]            resp_valid_o,
    output logic [DATA_WIDTH-1:0]         resp_data_o,
    output logic [ADDR_WIDTH-1:0]         ram_rd_addr_o,
    output logic                          ram_rd_o,
    output logic                          ram_output_reg_en_o,
    input  logic [DATA_WIDTH-1:0]         ram_rd_data_i
`ifdef RAM_RD_ARB_STATS_EN
    ,
    output logic [REQ_NUM*16-1:0]         grant_cnt_o
`endif
);

    localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int LAT   = (RAM_OUT_REG != 0) ? 2 : 1;

    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      ptr_d;
    logic                  gnt_any_s;
    logic [IDX_W-1:0]      gnt_idx_s;
    logic [ADDR_WIDTH-1:0] gnt_addr_s;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LAT-1:0]        tag_vld_q;
    logic [LAT-1:0]        tag_vld_d;
    logic [IDX_W-1:0]      tag_idx_q [LAT];
    logic [IDX_W-1:0]      tag_idx_d [LAT];

    // Cyclic search for the first valid client at or after the pointer.
    // Candidates are visited from the far end back to the pointer so the last
    // hit written is the nearest one. Reset masks the grant so nothing is
    // accepted while rst_n_i is low.
    always_comb begin : gnt_search
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        logic             hit;
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        sum       = '0;
        cand      = '0;
        hit       = 1'b0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            sum       = {1'b0, ptr_q} + (IDX_W+1)'(i);
            cand      = (sum >= (IDX_W+1)'(REQ_NUM)) ? IDX_W'(sum - (IDX_W+1)'(REQ_NUM))
                                                     : sum[IDX_W-1:0];
            hit       = req_valid_i[cand];
            gnt_any_s = gnt_any_s | hit;
            gnt_idx_s = hit ? cand : gnt_idx_s;
        end
        gnt_any_s = gnt_any_s & rst_n_i;
    end

    // Grant decode, RAM request drive and next-state for pointer/address.
    // When idle the address output replays the last issued address so the
    // RAM address bus only moves on real reads.
    always_comb begin : issue_comb
        gnt_addr_s    = req_addr_i[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
        req_ready_o   = '0;
        req_ready_o[gnt_idx_s] = gnt_any_s;
        ram_rd_o      = gnt_any_s;
        ram_rd_addr_o = gnt_any_s ? gnt_addr_s : addr_q;
        addr_d        = ram_rd_addr_o;
        if (gnt_any_s) begin
            ptr_d = (gnt_idx_s == IDX_W'(REQ_NUM - 1)) ? '0 : gnt_idx_s + IDX_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Tag pipeline next state: stage 0 captures this cycle's grant, later
    // stages shift along.
    always_comb begin : tag_comb
        tag_vld_d[0] = gnt_any_s;
        tag_idx_d[0] = gnt_idx_s;
        for (int s = 1; s < LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end
    end

    // Arbitration pointer, last address and tag pipeline registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin : state_ff
        if (!rst_n_i) begin
            ptr_q     <= '0;
            addr_q    <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            tag_vld_q <= tag_vld_d;
            for (int s = 0; s < LAT; s++) begin
                tag_idx_q[s] <= tag_idx_d[s];
            end
        end
    end

    // Response decode from the last tag stage; data passes straight through.
    // The RAM output register is clocked only while its input stage holds a
    // live read, which only exists when the RAM is built with that register.
    always_comb begin : resp_comb
        resp_valid_o = '0;
        resp_valid_o[tag_idx_q[LAT-1]] = tag_vld_q[LAT-1];
        resp_data_o  = ram_rd_data_i;
        ram_output_reg_en_o = (LAT > 1) ? tag_vld_q[0] : 1'b0;
    end

`ifdef RAM_RD_ARB_STATS_EN
    logic [15:0] cnt_q [REQ_NUM];
    logic [15:0] cnt_d [REQ_NUM];

    // Per-client saturating count of accepted requests.
    always_comb begin : cnt_comb
        for (int c = 0; c < REQ_NUM; c++) begin
            cnt_d[c] = cnt_q[c];
            if (req_ready_o[c] && (cnt_q[c] != 16'hFFFF)) begin
                cnt_d[c] = cnt_q[c] + 16'd1;
            end else begin
                cnt_d[c] = cnt_q[c];
            end
            grant_cnt_o[c*16 +: 16] = cnt_q[c];
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin : cnt_ff
        if (!rst_n_i) begin
            for (int c = 0; c < REQ_NUM; c++) begin
                cnt_q[c] <= 16'd0;
            end
        end else begin
            for (int c = 0; c < REQ_NUM; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ram_rd_arbiter. Two instances are exercised side by
// side: one with a plain RAM (latency 1) and one with the RAM output register
// (latency 2). Each is attached to a small behavioural RAM. A reference
// round-robin model predicts grants; every predicted read pushes the expected
// client/data/cycle onto a per-instance queue that is popped when the
// response is due.
// ---------------------------------------------------------------------------
module tb_ram_rd_arbiter;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int RN = 4;

    typedef struct packed {
        logic [31:0]   due;
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [RN-1:0]    v0 = '0, v1 = '0;
    logic [RN*AW-1:0] a0 = '0, a1 = '0;
    logic [RN-1:0]    rdy0, rdy1, rv0, rv1;
    logic [DW-1:0]    rdat0, rdat1, ramd0, ramd1;
    logic [AW-1:0]    ra0, ra1;
    logic             rr0, rr1, oe0, oe1;
`ifdef RAM_RD_ARB_STATS_EN
    logic [RN*16-1:0] gc0, gc1;
`endif

    ram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REQ_NUM(RN), .RAM_OUT_REG(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v0), .req_addr_i(a0),
        .req_ready_o(rdy0), .resp_valid_o(rv0), .resp_data_o(rdat0),
        .ram_rd_addr_o(ra0), .ram_rd_o(rr0), .ram_output_reg_en_o(oe0),
        .ram_rd_data_i(ramd0)
`ifdef RAM_RD_ARB_STATS_EN
        , .grant_cnt_o(gc0)
`endif
    );

    ram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REQ_NUM(RN), .RAM_OUT_REG(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v1), .req_addr_i(a1),
        .req_ready_o(rdy1), .resp_valid_o(rv1), .resp_data_o(rdat1),
        .ram_rd_addr_o(ra1), .ram_rd_o(rr1), .ram_output_reg_en_o(oe1),
        .ram_rd_data_i(ramd1)
`ifdef RAM_RD_ARB_STATS_EN
        , .grant_cnt_o(gc1)
`endif
    );

    // Behavioural RAMs (read-only contents)
    logic [DW-1:0] mem [32];
    logic [DW-1:0] q0, q1a, q1b;
    always @(posedge clk) if (rr0) q0 <= mem[ra0];
    always @(posedge clk) begin
        if (rr1) q1a <= mem[ra1];
        if (oe1) q1b <= q1a;
    end
    assign ramd0 = q0;
    assign ramd1 = q1b;

    // Bookkeeping
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];
    int   ptr_m [2];
    logic [AW-1:0] last_addr_m [2];
    logic prev_gnt_m [2];
    int   gcnt_m [2][RN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [RN-1:0] v, input int p);
        for (int i = 0; i < RN; i++) begin
            if (v[(p + i) % RN]) return (p + i) % RN;
        end
        return -1;
    endfunction

    task automatic mon_dut(input int d, input logic [RN-1:0] v, input logic [RN*AW-1:0] a,
                           input logic [RN-1:0] rdy, input logic [RN-1:0] rv,
                           input logic [DW-1:0] rdat, input logic [AW-1:0] ra,
                           input logic rr, input logic oe);
        exp_t e;
        logic have;
        int   qs;
        int   g;
        logic [AW-1:0] ga;
        if (!rst_n) begin
            check_eq($sformatf("d%0d_rst_ready", d), 32'(rdy), 32'd0);
            check_eq($sformatf("d%0d_rst_resp", d), 32'(rv), 32'd0);
            check_eq($sformatf("d%0d_rst_rd", d), 32'(rr), 32'd0);
            check_eq($sformatf("d%0d_rst_oe", d), 32'(oe), 32'd0);
            check_eq($sformatf("d%0d_rst_addr", d), 32'(ra), 32'd0);
            if (d == 0) sbq0.delete(); else sbq1.delete();
            ptr_m[d] = 0;
            last_addr_m[d] = '0;
            prev_gnt_m[d] = 1'b0;
            for (int c = 0; c < RN; c++) gcnt_m[d][c] = 0;
            return;
        end
        // response side
        qs = (d == 0) ? sbq0.size() : sbq1.size();
        have = 1'b0;
        e = '0;
        if (qs > 0) begin
            e = (d == 0) ? sbq0[0] : sbq1[0];
            have = (e.due == 32'(cyc));
        end
        if (have) begin
            if (d == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
            check_eq($sformatf("d%0d_resp_valid", d), 32'(rv), 32'(4'b0001 << e.idx));
            check_eq($sformatf("d%0d_resp_data", d), 32'(rdat), 32'(e.data));
        end else begin
            check_eq($sformatf("d%0d_resp_idle", d), 32'(rv), 32'd0);
        end
        check_eq($sformatf("d%0d_oreg_en", d), 32'(oe), (d == 1) ? 32'(prev_gnt_m[d]) : 32'd0);
        // request side
        g = rr_pick(v, ptr_m[d]);
        if (g >= 0) begin
            ga = a[g*AW +: AW];
            check_eq($sformatf("d%0d_ready", d), 32'(rdy), 32'(4'b0001 << g));
            check_eq($sformatf("d%0d_ram_rd", d), 32'(rr), 32'd1);
            check_eq($sformatf("d%0d_ram_addr", d), 32'(ra), 32'(ga));
            e.due  = 32'(cyc + d + 1);
            e.idx  = 2'(g);
            e.data = mem[ga];
            if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
            ptr_m[d] = (g + 1) % RN;
            last_addr_m[d] = ga;
            prev_gnt_m[d] = 1'b1;
            if (gcnt_m[d][g] < 65535) gcnt_m[d][g]++;
        end else begin
            check_eq($sformatf("d%0d_ready_idle", d), 32'(rdy), 32'd0);
            check_eq($sformatf("d%0d_ram_rd_idle", d), 32'(rr), 32'd0);
            check_eq($sformatf("d%0d_ram_addr_hold", d), 32'(ra), 32'(last_addr_m[d]));
            prev_gnt_m[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon_dut(0, v0, a0, rdy0, rv0, rdat0, ra0, rr0, oe0);
        mon_dut(1, v1, a1, rdy1, rv1, rdat1, ra1, rr1, oe1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = '0;
        v1 = '0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 17);
        mem[5] = 8'hA5;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // single read: client 1, address 5
        v0 = 4'b0010; a0 = {5'd0, 5'd0, 5'd5, 5'd0};
        v1 = 4'b0010; a1 = {5'd0, 5'd0, 5'd5, 5'd0};
        tick(1);
        v0 = '0; v1 = '0;
        tick(3);

        // fairness: all clients requesting from a fresh pointer
        do_reset();
        v0 = 4'hF; a0 = {5'd13, 5'd12, 5'd11, 5'd10};
        v1 = 4'hF; a1 = {5'd23, 5'd22, 5'd21, 5'd20};
        tick(12);
        v0 = '0; v1 = '0;
        tick(3);

        // back-to-back reads of 3 and 4 from client 3 on the registered RAM
        v1 = 4'b1000; a1 = {5'd3, 15'd0};
        tick(1);
        a1 = {5'd4, 15'd0};
        tick(1);
        v1 = '0;
        tick(4);

        // reset one cycle after a grant, then a lone request from client 2
        v0 = 4'b0001; a0 = {15'd0, 5'd7};
        v1 = 4'b0001; a1 = {15'd0, 5'd8};
        tick(1);
        v0 = '0; v1 = '0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        v0 = 4'b0100; a0 = {5'd0, 5'd9, 10'd0};
        v1 = 4'b0100; a1 = {5'd0, 5'd17, 10'd0};
        tick(1);
        v0 = '0; v1 = '0;
        tick(3);

        // sparse: clients 0 and 2 continuously from reset
        do_reset();
        v0 = 4'b0101; a0 = {5'd0, 5'd2, 5'd0, 5'd1};
        v1 = 4'b0101; a1 = {5'd0, 5'd30, 5'd0, 5'd31};
        tick(8);
        v0 = '0; v1 = '0;
        tick(2);

        // random traffic including requests that drop when about to be granted
        for (int i = 0; i < 300; i++) begin
            v0 = 4'($urandom_range(0, 15)); a0 = 20'($urandom);
            v1 = 4'($urandom_range(0, 15)); a1 = 20'($urandom);
            tick(1);
        end
        v0 = '0; v1 = '0;
        tick(4);

`ifdef RAM_RD_ARB_STATS_EN
        // stats: compare counters with the model, then saturate client 0
        for (int c = 0; c < RN; c++) begin
            check_eq($sformatf("d0_cnt%0d", c), 32'(gc0[c*16 +: 16]), 32'(gcnt_m[0][c]));
            check_eq($sformatf("d1_cnt%0d", c), 32'(gc1[c*16 +: 16]), 32'(gcnt_m[1][c]));
        end
        do_reset();
        v0 = 4'b0001; a0 = 20'd3;
        tick(65540);
        v0 = '0;
        tick(3);
        check_eq("d0_cnt0_sat", 32'(gc0[15:0]), 32'h0000FFFF);
        for (int c = 1; c < RN; c++) begin
            check_eq($sformatf("d0_cnt%0d_zero", c), 32'(gc0[c*16 +: 16]), 32'd0);
        end
`endif

        check_eq("d0_sb_drain", 32'(sbq0.size()), 32'd0);
        check_eq("d1_sb_drain", 32'(sbq1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
